// File: rtl/clk_gen_pkg.sv
// Shared constants and types for the clk_gen_multi clock-divider block.
// Optional feature macro used by this block: CLK_GEN_ALIGN_EN.
package clk_gen_pkg;

    localparam int unsigned CntWDefault = 32;
    localparam int unsigned DivDefault  = 50000;

    typedef logic [CntWDefault-1:0] div_t;

endpackage

// File: rtl/clk_gen_ch.sv
// One divider channel: half-period counter, divisor register, square-wave output and tick.
// Align input is always present here; the top ties it low unless CLK_GEN_ALIGN_EN is defined.
module clk_gen_ch
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned DIV_DEFAULT = DivDefault
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en_i,
    input  logic             align_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_div_i,
    output logic             wrap_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    assign wrap_o    = (count_q == div_q - CNT_W'(1));
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        clk_d   = clk_q;
        tick_d  = 1'b0;
        div_d   = load_i ? load_div_i : div_q;
        // Disable and align both park the channel high at count 0; the div load still lands.
        if (!en_i || align_i) begin
            count_d = '0;
            clk_d   = 1'b1;
        end else if (wrap_o) begin
            count_d = '0;
            clk_d   = ~clk_q;
            tick_d  = ~clk_q;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            div_q   <= CNT_W'(DIV_DEFAULT);
            clk_q   <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock divider with a single-slot divisor update port applied at period boundaries.
// Define CLK_GEN_ALIGN_EN to add the align_i input that phase-aligns all channels.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned DIV_DEFAULT = DivDefault,
    localparam int unsigned ChW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [ChW-1:0]    cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
`ifdef CLK_GEN_ALIGN_EN
    input  logic              align_i,
`endif
    output logic [NUM_CH-1:0] clk_out_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic             pend_q, pend_d;
    logic [ChW-1:0]   pch_q, pch_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             align_w;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] load;

`ifdef CLK_GEN_ALIGN_EN
    assign align_w = align_i;
`else
    assign align_w = 1'b0;
`endif

    assign cfg_ready_o = ~pend_q;

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = pend_q && (pch_q == ChW'(i)) && (wrap[i] || !ch_en_i[i] || align_w);
        end
    end

    // Accept and apply are mutually exclusive: accept needs an empty slot, apply a full one.
    always_comb begin
        pend_d = pend_q;
        pch_d  = pch_q;
        pdiv_d = pdiv_q;
        if (|load) begin
            pend_d = 1'b0;
        end else if (cfg_valid_i && !pend_q && (32'(cfg_ch_i) < NUM_CH)) begin
            pend_d = 1'b1;
            pch_d  = cfg_ch_i;
            pdiv_d = (cfg_div_i == '0) ? CNT_W'(1) : cfg_div_i;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            pch_q  <= '0;
            pdiv_q <= '0;
        end else begin
            pend_q <= pend_d;
            pch_q  <= pch_d;
            pdiv_q <= pdiv_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_gen_ch #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .clk_in     (clk_in),
            .reset      (reset),
            .en_i       (ch_en_i[g]),
            .align_i    (align_w),
            .load_i     (load[g]),
            .load_div_i (pdiv_q),
            .wrap_o     (wrap[g]),
            .clk_out_o  (clk_out_o[g]),
            .tick_o     (tick_o[g])
        );
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi against an event-time reference model.
// Exercises align_i when CLK_GEN_ALIGN_EN is defined.
module tb_clk_gen_multi;

    localparam int unsigned NCH  = 5;
    localparam int unsigned CW   = 16;
    localparam int unsigned DDEF = 4;

    logic           clk_in = 1'b0;
    logic           reset;
    logic [NCH-1:0] ch_en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [2:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           align;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    clk_gen_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DIV_DEFAULT (DDEF)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .ch_en_i     (ch_en),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_ch_i    (cfg_ch),
        .cfg_div_i   (cfg_div),
`ifdef CLK_GEN_ALIGN_EN
        .align_i     (align),
`endif
        .clk_out_o   (clk_out),
        .tick_o      (tick)
    );

    always #5 clk_in = ~clk_in;

    // Model: each channel knows the absolute edge number of its next toggle.
    longint      m_n;
    longint      m_nxt [NCH];
    int unsigned m_div [NCH];
    bit          m_lvl [NCH];
    bit          m_tick[NCH];
    bit          m_pend;
    int unsigned m_pch;
    int unsigned m_pdiv;

    int errs   = 0;
    int checks = 0;

    task automatic m_reset();
        m_n    = 0;
        m_pend = 0;
        for (int c = 0; c < NCH; c++) begin
            m_div[c]  = DDEF;
            m_nxt[c]  = DDEF;
            m_lvl[c]  = 1;
            m_tick[c] = 0;
        end
    endtask

    task automatic m_edge();
        bit al;
        bit apply;
        al = 0;
`ifdef CLK_GEN_ALIGN_EN
        al = align;
`endif
        m_n++;
        apply = m_pend && (!ch_en[m_pch] || m_n == m_nxt[m_pch] || al);
        for (int c = 0; c < NCH; c++) begin
            if (apply && c == int'(m_pch)) m_div[c] = m_pdiv;
            if (!ch_en[c] || al) begin
                m_lvl[c]  = 1;
                m_tick[c] = 0;
                m_nxt[c]  = m_n + m_div[c];
            end else if (m_n == m_nxt[c]) begin
                m_lvl[c]  = !m_lvl[c];
                m_tick[c] = m_lvl[c];
                m_nxt[c]  = m_n + m_div[c];
            end else begin
                m_tick[c] = 0;
            end
        end
        if (apply) begin
            m_pend = 0;
        end else if (cfg_valid && !m_pend && cfg_ch < NCH) begin
            m_pend = 1;
            m_pch  = cfg_ch;
            m_pdiv = (cfg_div == 0) ? 1 : cfg_div;
        end
    endtask

    task automatic check(input string tag);
        logic [NCH-1:0] ec;
        logic [NCH-1:0] et;
        logic           er;
        for (int c = 0; c < NCH; c++) begin
            ec[c] = m_lvl[c];
            et[c] = m_tick[c];
        end
        er = !m_pend;
        checks++;
        assert (clk_out === ec) else begin
            errs++;
            $error("FAIL %s clk_out got %b want %b edge %0d", tag, clk_out, ec, m_n);
        end
        checks++;
        assert (tick === et) else begin
            errs++;
            $error("FAIL %s tick got %b want %b edge %0d", tag, tick, et, m_n);
        end
        checks++;
        assert (cfg_ready === er) else begin
            errs++;
            $error("FAIL %s cfg_ready got %b want %b edge %0d", tag, cfg_ready, er, m_n);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_in);
        m_edge();
        #1;
        check(tag);
    endtask

    task automatic run(input int k, input string tag);
        for (int i = 0; i < k; i++) step(tag);
    endtask

    task automatic send(input logic [2:0] ch, input logic [CW-1:0] dv);
        bit done;
        cfg_valid = 1;
        cfg_ch    = ch;
        cfg_div   = dv;
        done      = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            done = cfg_ready;
            step("send");
        end
        cfg_valid = 0;
        checks++;
        assert (done) else begin
            errs++;
            $error("FAIL send_timeout got ready=0 want ready=1 within 64 cycles");
        end
    endtask

    initial begin
        reset     = 1;
        ch_en     = '1;
        cfg_valid = 0;
        cfg_ch    = '0;
        cfg_div   = '0;
        align     = 0;
        m_reset();
        #12;
        check("reset");
        reset = 0;

        run(20, "default_div");

        send(3'd1, CW'(2));
        run(16, "ch1_div2");

        send(3'd0, CW'(0));
        run(12, "ch0_div0");

        send(3'd7, CW'(3));
        run(8, "bad_ch");

        ch_en[2] = 0;
        run(10, "ch2_off");
        ch_en[2] = 1;
        run(12, "ch2_on");

        for (int i = 0; i < 400; i++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_div   = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
`ifdef CLK_GEN_ALIGN_EN
            align = ($urandom_range(0, 19) == 0);
`endif
            step("random");
        end
        cfg_valid = 0;
        align     = 0;
        ch_en     = '1;
        run(8, "settle");

        #2;
        reset = 1;
        #1;
        m_reset();
        check("async_reset");
        #2;
        reset = 0;
        run(20, "after_reset");

`ifdef CLK_GEN_ALIGN_EN
        send(3'd0, CW'(3));
        send(3'd1, CW'(5));
        for (int i = 0; i < 16 && !cfg_ready; i++) step("align_wait");
        run(7, "align_pre");
        align = 1;
        step("align_pulse");
        align = 0;
        run(14, "align_post");
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
